bht_predictor: RTL
==================

Name: bht_predictor

Overview:
- Parametrised branch history table (BHT) of saturating counters; successor to the single 2-bit saturating-counter branch predictor.
- Indexed by fetch PC, either directly (bimodal) or PC XOR global history (gshare).
- Separate lookup port (fetch stage) and update port (execute/resolve stage).
- Prediction is registered: 1-cycle latency. The index used is returned with the prediction so the pipeline can carry it to the update port.

Parameters:
- IDX_W, 6, index width; table has 2**IDX_W entries.
- CNT_W, 2, counter width in bits; legal range 1..4.
- GHR_W, 4, global history register width; legal range 1..IDX_W.
- MODE, 0, 0 = bimodal, 1 = gshare.
- ADDR_LSB, 2, lowest PC bit used for indexing; instruction-aligned bits are dropped.

Ports:
- clk, in, 1, clock; all state updates on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- lookup_vld, in, 1, lookup request this cycle.
- lookup_pc, in, 32, PC of the branch being fetched.
- pred_vld, out, 1, registered; lookup_vld delayed by 1 cycle.
- pred_take, out, 1, registered; predicted direction (1 = taken).
- pred_idx, out, IDX_W, registered; table index used for this prediction.
- upd_vld, in, 1, resolved branch this cycle.
- upd_idx, in, IDX_W, index returned earlier on pred_idx.
- upd_taken, in, 1, actual outcome of the resolved branch.
- ghr, out, GHR_W, current global history, for debug and checkpointing.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All counters = 2**CNT_W-1 (strongly taken).
  - ghr = 0, pred_vld = 0, pred_take = 0, pred_idx = 0.
- Index calculation:
  - base = lookup_pc[ADDR_LSB+IDX_W-1:ADDR_LSB].
  - MODE 0: idx = base.
  - MODE 1: idx = base XOR zero-extended ghr. ghr sits in the low GHR_W bits.
- Lookup:
  - On posedge with lookup_vld=1: pred_vld<=1, pred_idx<=idx, pred_take<=MSB of counter[idx].
  - With lookup_vld=0: pred_vld<=0; pred_take and pred_idx hold their previous values.
- Update, on posedge with upd_vld=1:
  - upd_taken=1: counter[upd_idx] increments, saturating at 2**CNT_W-1.
  - upd_taken=0: counter[upd_idx] decrements, saturating at 0.
  - No wrap-around in either direction.
- GHR:
  - On upd_vld=1: ghr <= {ghr[GHR_W-2:0], upd_taken}. For GHR_W=1: ghr <= upd_taken.
  - The shift happens in MODE 0 as well; only the indexing ignores ghr.
- Simultaneous lookup and update in the same cycle:
  - Lookup index is computed with the pre-update ghr.
  - If idx == upd_idx, pred_take reflects the post-update counter (write-first bypass).
  - If the indices differ, both operations proceed independently.
- CNT_W=2 state meaning: 3 = strongly taken, 2 = taken, 1 = not taken, 0 = strongly not taken. Prediction = MSB.
- Reset asserted mid-operation:
  - Table and ghr reinitialise immediately.
  - Any update presented during reset is discarded.
  - pred_vld drops to 0 asynchronously.
- Storage: flop array, no SRAM macro. Single write per cycle, so no write-port conflicts.
- Out-of-range parameters are rejected by an elaboration-time check.

Test Plan:
- Reset, then lookup pc=0x40 -> next cycle pred_vld=1, pred_take=1, pred_idx=0x10.
- MODE 0, CNT_W=2, lookups at the same index interleaved with updates taken=1,0,0,0,1,1,1:
  - After reset, before any update: pred_take=1.
  - After each update in turn: pred_take = 1,1,0,0,0,1,1.
  - Counter values along the way: 3,3,2,1,0,1,2,3.
- CNT_W=3, issue 10 updates with upd_taken=0, then 4 with upd_taken=1 -> counter stays at 0 (no wrap), then reaches 4 and pred_take=1 only after the 4th update.
- MODE 1, GHR_W=4, updates taken=1,0,1,1 (ghr=4'b1011), then lookup pc=0x40 -> pred_idx=0x10^0x0B=0x1B. Other entries are unaffected by updates to 0x1B.
- Same-cycle lookup and update to idx 5 (counter=2, upd_taken=0) -> pred_take=0 (bypass). A lookup to a different idx in the same cycle returns that entry's own value.
- Drive several updates to lower counters, pulse rst_n low mid-stream with upd_vld=1 -> pred_vld=0 immediately, ghr=0, every entry predicts taken, and the update issued during reset has no effect.

Source files
------------

// File: rtl/bht_predictor.sv
// Branch history table of saturating counters, indexed bimodally or by gshare.
// Registered prediction with the index returned alongside; write-first bypass on same-index update.
module bht_predictor #(
  parameter int IDX_W    = 6,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 4,
  parameter int MODE     = 0,
  parameter int ADDR_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_vld,
  input  logic [31:0]      lookup_pc,
  output logic             pred_vld,
  output logic             pred_take,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_vld,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic [GHR_W-1:0] ghr
);

  localparam int               ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (IDX_W < 1 || CNT_W < 1 || CNT_W > 4 || GHR_W < 1 || GHR_W > IDX_W ||
      (MODE != 0 && MODE != 1) || ADDR_LSB < 0 || ADDR_LSB + IDX_W > 32) begin : g_param_check
    $error("bht_predictor: parameter out of range");
  end

  // Valid-only interfaces, no back-pressure: a lookup_vld or upd_vld pulse is
  // consumed on the same posedge, and pred_vld is a one-cycle pulse per lookup.

  logic [CNT_W-1:0] cnt_q [ENTRIES];
  logic [IDX_W-1:0] base_idx;
  logic [IDX_W-1:0] ghr_ext;
  logic [IDX_W-1:0] lookup_idx;
  logic [CNT_W-1:0] upd_cur;
  logic [CNT_W-1:0] upd_nxt;
  logic [CNT_W-1:0] lookup_cnt;
  logic [GHR_W-1:0] ghr_nxt;
  logic             unused_pc;

  assign base_idx   = lookup_pc[ADDR_LSB+IDX_W-1:ADDR_LSB];
  assign ghr_ext    = IDX_W'(ghr);
  assign lookup_idx = (MODE == 1) ? (base_idx ^ ghr_ext) : base_idx;
  assign unused_pc  = ^lookup_pc;

  // Saturating step of the counter being resolved this cycle.
  always_comb begin
    upd_cur = cnt_q[upd_idx];
    upd_nxt = upd_cur;
    if (upd_taken) begin
      if (upd_cur != CNT_MAX) upd_nxt = upd_cur + 1'b1;
    end else begin
      if (upd_cur != '0) upd_nxt = upd_cur - 1'b1;
    end
  end

  // Write-first: a lookup hitting the entry being updated sees the new value.
  assign lookup_cnt = (upd_vld && (upd_idx == lookup_idx)) ? upd_nxt : cnt_q[lookup_idx];

  if (GHR_W == 1) begin : g_ghr_one
    assign ghr_nxt = upd_taken;
  end else begin : g_ghr_shift
    assign ghr_nxt = {ghr[GHR_W-2:0], upd_taken};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_MAX;
    end else if (upd_vld) begin
      cnt_q[upd_idx] <= upd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (upd_vld) begin
      ghr <= ghr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_vld  <= 1'b0;
      pred_take <= 1'b0;
      pred_idx  <= '0;
    end else begin
      pred_vld <= lookup_vld;
      if (lookup_vld) begin
        pred_take <= lookup_cnt[CNT_W-1];
        pred_idx  <= lookup_idx;
      end
    end
  end

endmodule
